// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared defaults and state encoding for the framebuffer
//                write sequencer (fb_write_sequencer, fb_fifo).
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int              DEF_ADDR_W      = 19;
    localparam int              DEF_DATA_W      = 12;
    localparam int              DEF_FIFO_DEPTH  = 8;
    localparam int              DEF_FB_WORDS    = 480000;
    localparam logic [11:0]     DEF_CLEAR_COLOR = 12'h000;

    // IDLE: buffer empty, DRAIN: buffer non-empty, CLEAR: full-screen sweep
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fb_fifo
//  Description : Synchronous FIFO with flush. DEPTH must be a power of two so
//                the pointers wrap naturally. Head is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 31
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Flush wins over both operations; overflow/underflow requests are ignored
    assign w_push  = push && !full  && !flush;
    assign w_pop   = pop  && !empty && !flush;
    assign full    = (r_count == OCC_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage array, written on accepted push only
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fb_write_sequencer
//  Description : Turns the drawing-stage pixel stream into one-per-cycle
//                framebuffer writes: drops transparent pixels, buffers bursts,
//                and runs the full-screen clear sweep on clear_req.
//                Optional macro FB_SEQ_DEDUP_EN suppresses a popped write that
//                repeats the last issued (addr, data) pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_write_sequencer
    import fb_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int                FB_WORDS    = DEF_FB_WORDS,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = DATA_W'(DEF_CLEAR_COLOR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int OCC_W   = $clog2(FIFO_DEPTH+1);
    // One extra count value marks "sweep finished" so the state stays in
    // CLEAR through the last write cycle and in_ready rises the cycle after
    localparam int CNT_W   = $clog2(FB_WORDS+1);

    fb_state_t          r_state;
    logic [CNT_W-1:0]   r_sweep;

    logic               w_full;
    logic               w_empty;
    logic [OCC_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic               w_clearing;
    logic               w_nonzero;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_sweep_done;
    logic               w_nonempty_next;
    logic               w_dup;

    assign w_clearing   = (r_state == CLEAR);
    assign in_ready     = !w_full && !w_clearing;
    assign w_nonzero    = (in_data != '0);
    assign w_push       = in_valid && in_ready && w_nonzero && !clear_req;
    assign w_pop        = !w_empty && !w_clearing && !clear_req;
    // A write arriving with clear_req is lost even when in_ready is high
    assign w_drop       = in_valid && w_nonzero && (!in_ready || clear_req);
    assign w_sweep_done = (r_sweep == CNT_W'(FB_WORDS));
    assign w_nonempty_next = w_push || (w_count > OCC_W'(1)) ||
                             ((w_count == OCC_W'(1)) && !w_pop);

    fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (clear_req),
        .wr_data ({in_addr, in_data}),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

`ifdef FB_SEQ_DEDUP_EN
    logic               r_last_vld;
    logic [ENTRY_W-1:0] r_last;

    // Remember the last popped entry; forgotten on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_vld <= 1'b0;
            r_last     <= '0;
        end else if (clear_req) begin
            r_last_vld <= 1'b0;
        end else if (w_pop) begin
            r_last_vld <= 1'b1;
            r_last     <= w_head;
        end
    end

    assign w_dup = r_last_vld && (r_last == w_head);
`else
    assign w_dup = 1'b0;
`endif

    // Main sequencer: state, sweep counter and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sweep <= '0;
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            busy    <= 1'b0;
        end else begin
            fb_we <= 1'b0;
            if (clear_req) begin
                // A restart keeps busy asserted; a fresh clear raises it next cycle
                r_state <= CLEAR;
                r_sweep <= '0;
                busy    <= w_clearing;
            end else begin
                case (r_state)
                    CLEAR: begin
                        if (w_sweep_done) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            fb_we   <= 1'b1;
                            fb_addr <= ADDR_W'(r_sweep);
                            fb_data <= CLEAR_COLOR;
                            busy    <= 1'b1;
                            r_sweep <= r_sweep + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= w_nonempty_next ? DRAIN : IDLE;
                        if (w_pop && !w_dup) begin
                            fb_we   <= 1'b1;
                            fb_addr <= w_head[ENTRY_W-1:DATA_W];
                            fb_data <= w_head[DATA_W-1:0];
                        end
                    end
                endcase
            end
        end
    end

    // Saturating count of lost non-transparent writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (w_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_write_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fb_write_sequencer
//  Description : Directed self-checking bench for fb_write_sequencer, built
//                with a shortened framebuffer (FB_WORDS = 2000).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_sequencer;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 12;
    localparam int FB_WORDS = 2000;
`ifdef FB_SEQ_DEDUP_EN
    localparam int DUP_EXP  = 1;
`else
    localparam int DUP_EXP  = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear_req;
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              busy;
    logic [7:0]        drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W+DATA_W-1:0] pq[$];   // pixel writes (busy low)
    logic [ADDR_W+DATA_W-1:0] cq[$];   // clear writes (busy high)
    int busy_cnt = 0;

    fb_write_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (8),
        .FB_WORDS    (FB_WORDS),
        .CLEAR_COLOR (12'h000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .in_valid  (in_valid),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #20 clk = ~clk;

    // Write-port monitor on the falling edge
    always @(negedge clk) begin
        if (fb_we && busy)  cq.push_back({fb_addr, fb_data});
        if (fb_we && !busy) pq.push_back({fb_addr, fb_data});
        if (busy)           busy_cnt = busy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int errs;
        logic [ADDR_W+DATA_W-1:0] e;

        rst_n = 1'b0; clear_req = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        #5;
        check("rst_we",    fb_we,    0);
        check("rst_addr",  fb_addr,  0);
        check("rst_data",  fb_data,  0);
        check("rst_ready", in_ready, 1);
        check("rst_busy",  busy,     0);
        check("rst_drop",  drop_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single write, two-cycle latency, one cycle wide
        in_valid = 1'b1; in_addr = 19'h00100; in_data = 12'h00F;
        tick();
        in_valid = 1'b0;
        check("single_lat1_we", fb_we, 0);
        tick();
        check("single_we",   fb_we,   1);
        check("single_addr", fb_addr, 19'h00100);
        check("single_data", fb_data, 12'h00F);
        tick();
        check("single_end_we", fb_we, 0);

        // Transparent pixel is discarded without counting
        in_valid = 1'b1; in_addr = 19'h00055; in_data = 12'h000;
        tick();
        in_valid = 1'b0;
        tick();
        check("zero_we1", fb_we, 0);
        tick();
        check("zero_we2", fb_we, 0);
        check("zero_drop", drop_cnt, 0);

        // Ten back-to-back writes
        pq.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_addr = 19'(32'h200 + i); in_data = 12'(32'h100 + i);
            tick();
            check($sformatf("burst_ready%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("burst_count", pq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            e = {19'(32'h200 + i), 12'(32'h100 + i)};
            check($sformatf("burst%0d", i), pq[i], e);
        end
        check("burst_drop", drop_cnt, 0);

        // Clear while entries are in flight; 0x303 is flushed, 0x304 dropped
        pq.delete(); cq.delete(); busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_addr = 19'(32'h300 + i); in_data = 12'h0A0;
            clear_req = (i == 4);
            tick();
        end
        in_valid = 1'b0; clear_req = 1'b0;
        check("clr0_busy",  busy,     0);
        check("clr0_ready", in_ready, 0);
        check("clr0_we",    fb_we,    0);
        tick();
        check("clr1_busy", busy,    1);
        check("clr1_we",   fb_we,   1);
        check("clr1_addr", fb_addr, 0);
        for (int k = 1; k < FB_WORDS; k++) begin
            in_valid = (k == 10) || (k == 20) || (k == 30) || (k == 40);
            in_data  = (k == 40) ? 12'h000 : 12'h0AB;
            in_addr  = 19'h00007;
            tick();
        end
        in_valid = 1'b0;
        check("clr_last_addr",  fb_addr,  FB_WORDS - 1);
        check("clr_last_busy",  busy,     1);
        check("clr_last_ready", in_ready, 0);
        tick();
        check("clr_end_busy",  busy,     0);
        check("clr_end_ready", in_ready, 1);
        check("clr_end_we",    fb_we,    0);
        check("clr_busy_cycles", busy_cnt, FB_WORDS);
        check("clr_words", cq.size(), FB_WORDS);
        errs = 0;
        for (int k = 0; k < cq.size(); k++) begin
            e = {19'(k), 12'h000};
            if (cq[k] !== e) errs++;
        end
        check("clr_seq_errs", errs, 0);
        check("clr_pix_count", pq.size(), 3);
        check("clr_pix0", pq[0], {19'h00300, 12'h0A0});
        check("clr_pix2", pq[2], {19'h00302, 12'h0A0});
        check("clr_drops", drop_cnt, 4);

        // Restart the sweep at address 1000
        cq.delete();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        check("rs_first_addr", fb_addr, 0);
        repeat (1000) tick();
        check("rs_at_1000", fb_addr, 1000);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("rs_busy_hold", busy, 1);
        check("rs_ready", in_ready, 0);
        tick();
        check("rs_restart_we",   fb_we,   1);
        check("rs_restart_addr", fb_addr, 0);
        repeat (FB_WORDS - 1) tick();
        check("rs_last_addr", fb_addr, FB_WORDS - 1);
        tick();
        check("rs_end_busy", busy, 0);
        check("rs_words", cq.size(), 1001 + FB_WORDS);
        check("rs_seq_mid", cq[1001], {19'h0, 12'h000});
        check("rs_seq_end", cq[1000 + FB_WORDS], {19'(FB_WORDS - 1), 12'h000});

        // Two identical writes
        pq.delete();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_addr = 19'h00005; in_data = 12'h0F0;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("dup_count", pq.size(), DUP_EXP);
        check("dup_first", pq[0], {19'h00005, 12'h0F0});

        // drop_cnt saturation during a sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < FB_WORDS; k++) begin
            in_valid = 1'b1; in_addr = 19'h00009; in_data = 12'h111;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("sat_drop", drop_cnt, 255);
        repeat (3) tick();

        // Reset in the middle of a sweep
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        check("mid_busy_pre", busy, 1);
        #5 rst_n = 1'b0;
        #1;
        check("mid_rst_we",    fb_we,    0);
        check("mid_rst_addr",  fb_addr,  0);
        check("mid_rst_busy",  busy,     0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_drop",  drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_post_busy", busy,  0);
        check("mid_post_we",   fb_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
